// File: rtl/inv_remap_pkg.sv
// Shared defines, node/intercept tables and FSM encodings for the piecewise-linear remap.
// Consumed by remap_fwd_eval and inv_remap (optional residual output: INV_REMAP_ERR_EN).
`ifndef INV_REMAP_SHARED_DEFINES
`define INV_REMAP_SHARED_DEFINES
`define M1_LENGTH  8
`define M2_LENGTH  7
`define NODE_NUM   5
`define PIECE_NUM  4
`define SEG1_NUM   1
`define SEG2_NUM   1
`define SEG3_NUM   1
`define SEG4_NUM   1
`define INV_IDLE   2'd0
`define INV_SEARCH 2'd1
`define INV_FINAL  2'd2
`define INV_DONE   2'd3
`endif

package inv_remap_pkg;

  // Piece p covers NODE_TBL[p] < m1 <= NODE_TBL[p+1]; intercepts chosen so f stays monotonic.
  localparam logic [`M1_LENGTH-1:0] NODE_TBL [`NODE_NUM] =
    '{8'd0, 8'd8, 8'd64, 8'd160, 8'd224};
  localparam logic [`M1_LENGTH-1:0] INTERCEPT_TBL [`PIECE_NUM] =
    '{8'd0, 8'd31, 8'd38, 8'd57};

  typedef enum logic [1:0] {
    SEG_ADD4X,
    SEG_ZERO,
    SEG_SUB8TH,
    SEG_SUB4TH
  } seg_e;

  typedef enum logic [1:0] {
    ST_IDLE   = `INV_IDLE,
    ST_SEARCH = `INV_SEARCH,
`ifdef INV_REMAP_ERR_EN
    ST_FINAL  = `INV_FINAL,
`endif
    ST_DONE   = `INV_DONE
  } inv_state_e;

  // Pieces are grouped by segment type in table order.
  function automatic seg_e piece_seg(input int p);
    if (p < `SEG1_NUM) return SEG_ADD4X;
    if (p < `SEG1_NUM + `SEG2_NUM) return SEG_ZERO;
    if (p < `SEG1_NUM + `SEG2_NUM + `SEG3_NUM) return SEG_SUB8TH;
    return SEG_SUB4TH;
  endfunction

endpackage

// File: rtl/remap_fwd_eval.sv
// Combinational forward remap f(m1): per-piece adder plus intercept, wrapped to M1_W bits, then halved.
// Shared by the inverse search and the forward path.
module remap_fwd_eval
  import inv_remap_pkg::*;
#(
  parameter int M1_W = `M1_LENGTH,
  parameter int M2_W = `M2_LENGTH
) (
  input  logic [M1_W-1:0] m1_i,
  output logic [M2_W-1:0] f_o
);

  logic [M1_W-1:0] adder;
  logic [M1_W-1:0] sum;
  logic            hit;

  // NOTE: every variable assigned in this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    adder = '0;
    sum   = m1_i;
    hit   = 1'b0;
    for (int p = 0; p < `PIECE_NUM; p++) begin
      if (!hit && (m1_i > M1_W'(NODE_TBL[p])) && (m1_i <= M1_W'(NODE_TBL[p+1]))) begin
        hit = 1'b1;
        unique case (piece_seg(p))
          SEG_ADD4X:  adder = m1_i << 2;
          SEG_ZERO:   adder = '0;
          SEG_SUB8TH: adder = M1_W'(0) - (m1_i >> 3);
          SEG_SUB4TH: adder = M1_W'(0) - (m1_i >> 2);
          default:    adder = '0;
        endcase
        sum = m1_i + adder + M1_W'(INTERCEPT_TBL[p]);
      end
    end
    f_o = sum[M1_W-1:1];
  end

endmodule

// File: rtl/inv_remap.sv
// Inverse remap: successive-approximation search for the largest m1 with f(m1) <= target.
// Define INV_REMAP_ERR_EN to add the FINAL state and the out_err residual port.
module inv_remap
  import inv_remap_pkg::*;
#(
  parameter int M1_W = `M1_LENGTH,
  parameter int M2_W = `M2_LENGTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M2_W-1:0] in_m2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M1_W-1:0] out_m1
`ifdef INV_REMAP_ERR_EN
  ,
  output logic [M2_W-1:0] out_err
`endif
);

  localparam int BIT_W = (M1_W > 1) ? $clog2(M1_W) : 1;

  inv_state_e       state_q, state_d;
  logic [M2_W-1:0]  tgt_q, tgt_d;
  logic [M1_W-1:0]  res_q, res_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [M1_W-1:0]  trial;
  logic [M1_W-1:0]  eval_in;
  logic [M2_W-1:0]  f_val;
`ifdef INV_REMAP_ERR_EN
  logic [M2_W-1:0]  err_q, err_d;
`endif

  assign trial = res_q | (M1_W'(1) << bit_q);

  remap_fwd_eval #(
    .M1_W (M1_W),
    .M2_W (M2_W)
  ) u_fwd (
    .m1_i (eval_in),
    .f_o  (f_val)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    res_d   = res_q;
    bit_d   = bit_q;
    eval_in = trial;
`ifdef INV_REMAP_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          tgt_d   = in_m2;
          res_d   = '0;
          bit_d   = BIT_W'(M1_W - 1);
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (f_val <= tgt_q) res_d = trial;
        if (bit_q == '0) begin
`ifdef INV_REMAP_ERR_EN
          state_d = ST_FINAL;
`else
          state_d = ST_DONE;
`endif
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
`ifdef INV_REMAP_ERR_EN
      // The evaluator is shared: here it sees the settled result instead of a trial value.
      ST_FINAL: begin
        eval_in = res_q;
        err_d   = tgt_q - f_val;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      res_q   <= '0;
      bit_q   <= '0;
`ifdef INV_REMAP_ERR_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      res_q   <= res_d;
      bit_q   <= bit_d;
`ifdef INV_REMAP_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_m1    = res_q;
`ifdef INV_REMAP_ERR_EN
  assign out_err   = err_q;
`endif

endmodule
